seq_checker: RTL and testbench

//  Receive-side checker for the 4-bit counter sequence emitted on Q by the sequence generator.
//  - Samples the stream and predicts each next value (prev + STEP, mod 2^W).
//  - Acquires lock and counts mismatches.
//  - Sits beside/after the generator on the same CLK domain as a built-in self-check monitor.

---
 rtl/seq_checker_if.sv | 22 ++
 rtl/seq_checker.sv | 118 +++++++++++
 tb/tb_seq_checker.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/seq_checker_if.sv
// Stream/status bundle between a sequence source and seq_checker.
// The source drives D/VALID; the checker drives the lock status.
interface seq_checker_if #(
    parameter int W = 4
);
    logic [W-1:0] D;
    logic         VALID;
    logic         LOCKED;
    logic         ERR;
    logic [7:0]   ERR_CNT;
    logic [1:0]   STATE;

    modport master (
        output D, VALID,
        input  LOCKED, ERR, ERR_CNT, STATE
    );

    modport slave (
        input  D, VALID,
        output LOCKED, ERR, ERR_CNT, STATE
    );
endinterface

// File: rtl/seq_checker.sv
// Receive-side checker for a counting stream: seeds, locks, counts misses.
// Option: SEQ_CHECKER_STICKY_FAIL_EN makes lock loss terminal (FAIL) until RST.
module seq_checker #(
    parameter int W         = 4,
    parameter int STEP      = 1,
    parameter int LOCK_CNT  = 4,
    parameter int ERR_LIMIT = 2
) (
    input logic         CLK,
    input logic         RST,
    seq_checker_if.slave bus
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);

    localparam logic [W-1:0]  STEP_V = W'(STEP);
    localparam logic [MW-1:0] M_ONE  = MW'(1);
    localparam logic [MW-1:0] LOCK_V = MW'(LOCK_CNT);
    localparam logic [EW-1:0] E_ONE  = EW'(1);
    localparam logic [EW-1:0] ELIM_V = EW'(ERR_LIMIT);

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCKD  = 2'b10,
        FAIL   = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  pred_q, pred_d;
    logic [MW-1:0] match_q, match_d;
    logic [EW-1:0] miss_q, miss_d;
    logic          err_q, err_d;
    logic [7:0]    cnt_q, cnt_d;

    logic [W-1:0]  next_pred;
    logic          hit;

    assign next_pred = bus.D + STEP_V;
    assign hit       = (bus.D == pred_q);

    // State and counter registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= HUNT;
            pred_q  <= '0;
            match_q <= '0;
            miss_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pred_q  <= pred_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: seed, verify run length, track misses while locked
    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (bus.VALID) begin
            case (state_q)
                HUNT: begin
                    pred_d  = next_pred;
                    match_d = M_ONE;
                    state_d = VERIFY;
                end
                VERIFY: begin
                    pred_d = next_pred;
                    if (hit) begin
                        match_d = match_q + M_ONE;
                        if (match_q + M_ONE == LOCK_V) begin
                            state_d = LOCKD;
                            miss_d  = '0;
                        end
                    end else begin
                        match_d = M_ONE;
                    end
                end
                LOCKD: begin
                    pred_d = next_pred;
                    if (hit) begin
                        miss_d = '0;
                    end else begin
                        err_d  = 1'b1;
                        miss_d = miss_q + E_ONE;
                        if (cnt_q != 8'hFF) begin
                            cnt_d = cnt_q + 8'd1;
                        end
                        if (miss_q + E_ONE == ELIM_V) begin
`ifdef SEQ_CHECKER_STICKY_FAIL_EN
                            state_d = FAIL;
`else
                            state_d = HUNT;
                            match_d = '0;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.LOCKED  = (state_q == LOCKD);
    assign bus.ERR     = err_q;
    assign bus.ERR_CNT = cnt_q;
    assign bus.STATE   = state_q;

endmodule

// File: tb/tb_seq_checker.sv
// Randomized + directed bench for seq_checker against a run-length model.
// Honours SEQ_CHECKER_STICKY_FAIL_EN when defined at build time.
module tb_seq_checker;
    localparam int W         = 4;
    localparam int LOCK_CNT  = 4;
    localparam int ERR_LIMIT = 2;
    localparam int MOD       = 16;

`ifdef SEQ_CHECKER_STICKY_FAIL_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;

    seq_checker_if #(.W(W)) bus ();

    seq_checker #(
        .W(W), .STEP(1), .LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: stream knowledge expressed as seed/run/miss bookkeeping
    bit m_seeded, m_locked, m_failed, m_err;
    int m_pred, m_run, m_miss, m_errcnt;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        m_seeded = 0; m_locked = 0; m_failed = 0; m_err = 0;
        m_pred = 0; m_run = 0; m_miss = 0; m_errcnt = 0;
    endfunction

    function automatic void m_step(input bit v, input int d);
        m_err = 0;
        if (!v || m_failed) return;
        if (!m_seeded) begin
            m_seeded = 1;
            m_run = 1;
        end else if (m_locked) begin
            if (d == m_pred) m_miss = 0;
            else begin
                m_err = 1;
                if (m_errcnt < 255) m_errcnt++;
                m_miss++;
                if (m_miss == ERR_LIMIT) begin
                    m_locked = 0;
                    if (STICKY) m_failed = 1;
                    else m_seeded = 0;
                end
            end
        end else begin
            if (d == m_pred) begin
                m_run++;
                if (m_run == LOCK_CNT) begin
                    m_locked = 1;
                    m_miss = 0;
                end
            end else m_run = 1;
        end
        m_pred = (d + 1) % MOD;
    endfunction

    function automatic int m_state();
        if (m_failed) return 3;
        if (m_locked) return 2;
        if (m_seeded) return 1;
        return 0;
    endfunction

    task automatic cyc(input bit r, input bit v, input int d, input string tag);
        RST = r;
        bus.VALID = v;
        bus.D = W'(d);
        @(posedge CLK);
        if (r) m_reset();
        else m_step(v, d);
        #1;
        check({tag, ".LOCKED"}, int'(bus.LOCKED), int'(m_locked));
        check({tag, ".ERR"}, int'(bus.ERR), int'(m_err));
        check({tag, ".ERR_CNT"}, int'(bus.ERR_CNT), m_errcnt);
        check({tag, ".STATE"}, int'(bus.STATE), m_state());
    endtask

    task automatic feed(input int vals[$], input string tag);
        foreach (vals[i]) cyc(1'b0, 1'b1, vals[i], tag);
    endtask

    initial begin
        bus.D = '0;
        bus.VALID = 1'b0;
        m_reset();
        @(negedge CLK);

        // T1 lock on 0..3
        cyc(1'b1, 1'b0, 0, "t1rst");
        feed('{0, 1, 2, 3}, "t1");
        check("t1.lock", int'(bus.LOCKED), 1);
        // T2 wrap while locked
        feed('{4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1}, "t2");
        // T3 single miss then recovery
        cyc(1'b1, 1'b0, 0, "t3rst");
        feed('{1, 2, 3, 4, 9, 10, 11}, "t3");
        check("t3.cnt", int'(bus.ERR_CNT), 1);
        // T4 two misses drop lock
        cyc(1'b1, 1'b0, 0, "t4rst");
        feed('{0, 1, 2, 3, 9, 3}, "t4");
        check("t4.cnt", int'(bus.ERR_CNT), 2);
        feed('{3, 4, 5, 6, 7}, "t4b");
        // T5 reseed in VERIFY
        cyc(1'b1, 1'b0, 0, "t5rst");
        feed('{0, 1, 7, 8, 9, 10}, "t5");
        // T6 gaps ignored, then reset while locked
        cyc(1'b1, 1'b0, 0, "t6rst");
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, i, "t6v");
            cyc(1'b0, 1'b0, $urandom_range(0, 15), "t6g");
        end
        cyc(1'b1, 1'b1, 5, "t6rst2");
        check("t6.rstcnt", int'(bus.ERR_CNT), 0);

        // Saturation: alternating miss/match stays locked
        feed('{0, 1, 2, 3}, "satlk");
        for (int i = 0; i < 262; i++) begin
            cyc(1'b0, 1'b1, (m_pred + 7) % MOD, "satmiss");
            cyc(1'b0, 1'b1, m_pred, "sathit");
        end
        check("sat.cnt", int'(bus.ERR_CNT), 255);

        // Random: mostly in-sequence, some junk, gaps, rare reset
        cyc(1'b1, 1'b0, 0, "rrst");
        for (int i = 0; i < 3000; i++) begin
            bit r, v;
            int d;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 9) < 8) ? m_pred : $urandom_range(0, 15);
            cyc(r, v, d, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
